// File: rtl/mmm_share_arbiter_if.sv
// mmm_share_arbiter_if: requester-side and MMM-side bus of the shared multiplier arbiter.
interface mmm_share_arbiter_if #(parameter int WIDTH = 8, parameter int NREQ = 2);
  logic [NREQ-1:0] req, gnt, done;
  logic [NREQ*WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] result, mmm_a, mmm_b, mmm_result;
  logic busy, err, mmm_start, mmm_done;
  modport master (output req, op_a, op_b, mmm_done, mmm_result,
                  input gnt, done, result, busy, err, mmm_start, mmm_a, mmm_b);
  modport slave (input req, op_a, op_b, mmm_done, mmm_result,
                 output gnt, done, result, busy, err, mmm_start, mmm_a, mmm_b);
endinterface

// File: rtl/mmm_share_arbiter.sv
// mmm_share_arbiter: round-robin sharing of one Montgomery multiplier among NREQ requesters.
// Define MMM_WATCHDOG_EN to add a WAIT-state timeout that completes with err=1 and result=0.
module mmm_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  mmm_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("mmm_share_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, last_q, last_d, sel;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d, a_q, a_d, b_q, b_d;
  logic busy_q, busy_d, start_q, start_d;
`ifdef MMM_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  // First asserted request searching upward from last_gnt+1; last_gnt itself has lowest priority.
  always_comb begin
    sel = last_q;
    for (int i = NREQ; i >= 1; i--)
      if (bus.req[(int'(last_q) + i) % NREQ]) sel = IW'((int'(last_q) + i) % NREQ);
  end
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    start_d  = 1'b0;
`ifdef MMM_WATCHDOG_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d    = ISSUE;
        idx_d      = sel;
        gnt_d      = '0;
        gnt_d[sel] = 1'b1;
        a_d        = bus.op_a[int'(sel)*WIDTH +: WIDTH];
        b_d        = bus.op_b[int'(sel)*WIDTH +: WIDTH];
        start_d    = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MMM_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      WAIT: if (bus.mmm_done) begin
        state_d  = RESP;
        result_d = bus.mmm_result;
        done_d   = gnt_q;
      end
`ifdef MMM_WATCHDOG_EN
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d  = RESP;
        result_d = '0;
        done_d   = gnt_q;
        err_d    = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      RESP: begin
        state_d = IDLE;
        last_d  = idx_q;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= IW'(NREQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
`ifdef MMM_WATCHDOG_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else if (ena) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
`ifdef MMM_WATCHDOG_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.mmm_start = start_q;
  assign bus.mmm_a     = a_q;
  assign bus.mmm_b     = b_q;
`ifdef MMM_WATCHDOG_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mmm_share_arbiter.sv
// tb_mmm_share_arbiter: directed bench with an MMM model and a scoreboard of expected done pulses.
`define CHK(tag, obs, exp) begin nchk++; assert ((obs) === (exp)) else begin nfail++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end end
module tb_mmm_share_arbiter;
  logic clk = 1'b0, rstb = 1'b0, ena = 1'b1;
  always #5 clk = ~clk;
  mmm_share_arbiter_if #(.WIDTH(8), .NREQ(2)) bus();
  mmm_share_arbiter #(.WIDTH(8), .NREQ(2), .TIMEOUT(32)) dut (.clk(clk), .rstb(rstb), .ena(ena), .bus(bus));

  typedef struct { logic [1:0] d; logic [7:0] r; logic e; } exp_t;
  exp_t sb[$];
  int nchk = 0, nfail = 0, cyc = 0;
  int mdelay = 0, mcnt = 0, nstart = 0, start_cyc = 0, md_cyc = 0, done_cyc = 0;
  logic [7:0] moff = 8'h00, start_a, start_b;
  logic [1:0] start_gnt;
  int c, s, n0, prev_done;

  function automatic logic [7:0] opsum(int i);
    return bus.op_a[i*8 +: 8] + bus.op_b[i*8 +: 8];
  endfunction
  function automatic void push(logic [1:0] d, logic [7:0] r, logic e);
    exp_t x;
    x.d = d; x.r = r; x.e = e;
    sb.push_back(x);
  endfunction

  // One clock; the MMM model and the done-pulse scoreboard run here, #1 after the edge.
  task automatic tick();
    exp_t x;
    @(posedge clk); #1; cyc++;
    bus.mmm_done = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin bus.mmm_done = 1'b1; md_cyc = cyc; end
    end
    if (bus.mmm_start) begin
      nstart++; start_cyc = cyc;
      start_a = bus.mmm_a; start_b = bus.mmm_b; start_gnt = bus.gnt;
      bus.mmm_result = bus.mmm_a + bus.mmm_b + moff;
      mcnt = mdelay;
    end
    if (|bus.done) begin
      done_cyc = cyc;
      if (sb.size() == 0) begin
        nchk++; nfail++;
        $error("FAIL unexpected_done: observed done=%0h expected none", bus.done);
      end else begin
        x = sb.pop_front();
        `CHK("sb_done", bus.done, x.d)
        `CHK("sb_result", bus.result, x.r)
        `CHK("sb_err", bus.err, x.e)
      end
    end
  endtask
  task automatic wait_done(string tag, int budget);
    for (int k = 0; k < budget; k++) begin tick(); if (|bus.done) return; end
    nchk++; nfail++;
    $error("FAIL %s: observed no done in %0d cycles, expected done", tag, budget);
  endtask
  task automatic wait_start(string tag, int budget);
    for (int k = 0; k < budget; k++) begin tick(); if (bus.mmm_start) return; end
    nchk++; nfail++;
    $error("FAIL %s: observed no mmm_start in %0d cycles, expected start", tag, budget);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req = '0; bus.op_a = {8'h9C, 8'h35}; bus.op_b = {8'h27, 8'h4A};
    bus.mmm_done = 1'b0; bus.mmm_result = '0;
    tick(); tick();
    rstb = 1'b1;
    `CHK("rst_gnt", bus.gnt, 2'b00)
    `CHK("rst_done", bus.done, 2'b00)
    `CHK("rst_busy", bus.busy, 1'b0)
    `CHK("rst_start", bus.mmm_start, 1'b0)
    `CHK("rst_result", bus.result, 8'h00)
    `CHK("rst_err", bus.err, 1'b0)

    // Single transaction, MMM answers 10 cycles after start with 0x12.
    moff = 8'h93; mdelay = 10; push(2'b01, 8'h12, 1'b0);
    bus.req = 2'b01; c = cyc; n0 = nstart;
    wait_done("t1_done", 40);
    `CHK("t1_start_lat", start_cyc, c + 1)
    `CHK("t1_start_cnt", nstart - n0, 1)
    `CHK("t1_mmm_a", start_a, 8'h35)
    `CHK("t1_mmm_b", start_b, 8'h4A)
    `CHK("t1_gnt", start_gnt, 2'b01)
    `CHK("t1_mmm_lat", md_cyc, start_cyc + 10)
    `CHK("t1_done_lat", done_cyc, md_cyc + 1)
    `CHK("t1_busy_resp", bus.busy, 1'b1)
    bus.req = 2'b00; moff = 8'h00;
    tick();
    `CHK("t1_busy_fall", bus.busy, 1'b0)
    `CHK("t1_done_fall", bus.done, 2'b00)
    `CHK("t1_result_hold", bus.result, 8'h12)
    `CHK("t1_gnt_clr", bus.gnt, 2'b00)

    // Fairness from reset: four transactions alternate 0,1,0,1 with one idle bubble.
    rstb = 1'b0; tick(); rstb = 1'b1;
    mdelay = 3;
    for (int k = 0; k < 4; k++) push(k % 2 ? 2'b10 : 2'b01, opsum(k % 2), 1'b0);
    bus.req = 2'b11; prev_done = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start("t2_start", 20);
      `CHK("t2_gnt", start_gnt, k % 2 ? 2'b10 : 2'b01)
      if (k > 0) `CHK("t2_bubble", start_cyc, prev_done + 2)
      wait_done("t2_done", 20);
      prev_done = done_cyc;
    end
    bus.req = 2'b00; tick();
    `CHK("t2_idle", bus.busy, 1'b0)

    // Requester 0 drops req mid-WAIT while requester 1 raises its own.
    mdelay = 8; push(2'b01, opsum(0), 1'b0); push(2'b10, opsum(1), 1'b0);
    bus.req = 2'b01;
    wait_start("t3_start0", 10);
    tick(); tick();
    bus.req = 2'b10;
    wait_done("t3_done0", 20);
    wait_start("t3_start1", 10);
    `CHK("t3_gnt1", start_gnt, 2'b10)
    `CHK("t3_mmm_a1", start_a, 8'h9C)
    wait_done("t3_done1", 20);
    bus.req = 2'b00; tick();

    // Frozen arbiter ignores a pending request until ena returns.
    mdelay = 4; push(2'b01, opsum(0), 1'b0);
    ena = 1'b0; bus.req = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      `CHK("t4_frozen_gnt", bus.gnt, 2'b00)
      `CHK("t4_frozen_start", bus.mmm_start, 1'b0)
    end
    ena = 1'b1; tick();
    `CHK("t4_gnt", bus.gnt, 2'b01)
    `CHK("t4_start", bus.mmm_start, 1'b1)
    wait_done("t4_done", 20);
    bus.req = 2'b00; tick();

    // Reset in WAIT abandons the transaction; pointer returns to requester 0 first.
    mdelay = 20; bus.req = 2'b10;
    wait_start("t5_start", 10);
    tick(); tick(); tick();
    rstb = 1'b0; bus.req = 2'b00; mcnt = 0;
    tick(); rstb = 1'b1;
    `CHK("t5_gnt", bus.gnt, 2'b00)
    `CHK("t5_busy", bus.busy, 1'b0)
    `CHK("t5_mmm_a", bus.mmm_a, 8'h00)
    `CHK("t5_mmm_b", bus.mmm_b, 8'h00)
    `CHK("t5_result", bus.result, 8'h00)
    mdelay = 3; push(2'b01, opsum(0), 1'b0); push(2'b10, opsum(1), 1'b0);
    bus.req = 2'b11;
    wait_start("t5_start0", 10);
    `CHK("t5_first_gnt", start_gnt, 2'b01)
    wait_done("t5_done0", 20);
    wait_done("t5_done1", 20);
    bus.req = 2'b00; tick();

    // MMM never answers.
    mdelay = 0; bus.req = 2'b01;
`ifdef MMM_WATCHDOG_EN
    push(2'b01, 8'h00, 1'b1);
    wait_start("t6_start", 10); s = start_cyc;
    wait_done("t6_wd_done", 60);
    `CHK("t6_wd_lat", done_cyc, s + 33)
    bus.req = 2'b00; tick();
    // mmm_done on the timeout cycle is a normal completion.
    mdelay = 32; push(2'b01, opsum(0), 1'b0);
    bus.req = 2'b01;
    wait_done("t6_tie_done", 60);
    bus.req = 2'b00; tick();
`else
    wait_start("t6_start", 10);
    for (int k = 0; k < 60; k++) tick();
    `CHK("t6_busy_stuck", bus.busy, 1'b1)
    `CHK("t6_err", bus.err, 1'b0)
    `CHK("t6_no_done", bus.done, 2'b00)
    rstb = 1'b0; bus.req = 2'b00; tick(); rstb = 1'b1; tick();
`endif
    `CHK("sb_empty", sb.size(), 0)
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/mmm_share_arbiter.md
Name: mmm_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Montgomery modular multiplier (MMM) between NREQ requesters, such as several exponentiation control units or a host path.
- Latches the winning requester's operands and drives the MMM with a one-cycle start pulse.
- Waits for the MMM done indication, captures the result, and returns it with a one-cycle done pulse to the granted requester.
- Sits between the requester FSMs and the single MMM datapath instance.

Parameters:
WIDTH, 8, operand/result width in bits
NREQ, 2, number of requesters (2..8)
TIMEOUT, 32, watchdog limit in WAIT cycles (used only with MMM_WATCHDOG_EN)

Ports:
clk  input  1  clock, rising edge
rstb  input  1  reset, synchronous, active-low
ena  input  1  global enable; when low, all registers hold
req  input  NREQ  per-requester request, level, held until its done pulse
op_a  input  NREQ*WIDTH  operand A of requester i at [i*WIDTH +: WIDTH]
op_b  input  NREQ*WIDTH  operand B of requester i, same packing
gnt  output  NREQ  one-hot grant, high from ISSUE through RESP
done  output  NREQ  one-cycle completion pulse to the granted requester
result  output  WIDTH  captured MMM result, valid while done is high and held until the next capture
busy  output  1  high in every state except IDLE
err  output  1  one-cycle watchdog error pulse, coincident with done
mmm_start  output  1  one-cycle start pulse to the MMM
mmm_a  output  WIDTH  latched operand A to the MMM
mmm_b  output  WIDTH  latched operand B to the MMM
mmm_done  input  1  MMM completion, sampled in WAIT only
mmm_result  input  WIDTH  MMM result, valid with mmm_done

Behaviour:
- Reset:
  - rstb low at a rising clk edge puts the FSM in IDLE and the round-robin pointer last_gnt at NREQ-1, so requester 0 wins first.
  - It also clears gnt, done, result, busy, err, mmm_start, mmm_a, mmm_b and the watchdog counter.
  - Reset has priority over ena.
  - Reset mid-operation abandons the transaction; no done pulse is issued.
- ena=0 freezes the state, counters and all registered outputs. Registered pulses (mmm_start, done, err) hold their value while frozen.
- FSM states are IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If req is non-zero, select the first asserted index searching upward from last_gnt+1, modulo NREQ.
  - Latch that index and its op_a/op_b slices into mmm_a/mmm_b, set gnt one-hot, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE: mmm_start=1 for exactly this cycle; go to WAIT. mmm_a/mmm_b stay stable from ISSUE through RESP.
- WAIT:
  - mmm_start=0.
  - When mmm_done=1, load result<=mmm_result and go to RESP.
  - mmm_done seen in IDLE, ISSUE or RESP is ignored.
- RESP: done[idx]=1 for one cycle, last_gnt<=idx, gnt cleared on exit; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle t gives mmm_start at t+1.
  - mmm_done at cycle d gives done at d+1, and IDLE at d+2.
  - The next arbitration is at d+2, so there is one bubble cycle between transactions.
- A requester that drops req mid-transaction does not abort it; done is still pulsed.
- Requests from other requesters during a transaction are ignored until IDLE. No request is lost because req is level-held.
- Fairness: with all requesters constantly asserting, grants rotate 0,1,...,NREQ-1,0.
- Index width is $clog2(NREQ). Watchdog counter width is $clog2(TIMEOUT+1).

Optional Feature:
MMM_WATCHDOG_EN
- Defined:
  - A counter clears in ISSUE and increments every enabled WAIT cycle.
  - If it reaches TIMEOUT without mmm_done, go to RESP with result<=0 and err=1 coincident with done[idx].
  - mmm_done arriving in the same cycle as the timeout wins (normal completion, err=0).
- Not defined: no counter is built, WAIT lasts until mmm_done, and err is tied 0.

Test Plan:
1. WIDTH=8, NREQ=2; req=01, op_a0=0x35, op_b0=0x4A; MMM model returns 0x12 with mmm_done 10 cycles after start -> mmm_start is a single pulse one cycle after req is sampled, mmm_a=0x35, mmm_b=0x4A, gnt=01, done=01 one cycle after mmm_done, result=0x12, busy falls the following cycle.
2. From reset, req=11 held for 4 transactions -> gnt sequence 01,10,01,10; each done pulse goes to the matching requester; one IDLE bubble between transactions.
3. req=10 asserted while requester 0's transaction is in WAIT, with req0 dropped at the same time -> requester 0 still receives done=01, then requester 1 is granted.
4. ena=0 for 5 cycles while req=01 is in IDLE -> gnt stays 00 and mmm_start stays 0; ena=1 -> normal grant on the next edge.
5. rstb=0 for 1 cycle during WAIT -> next cycle all outputs are 0 and the FSM is in IDLE; a later req=11 grants requester 0 first; no done is issued for the aborted transaction.
6. With MMM_WATCHDOG_EN and TIMEOUT=32, mmm_done never asserted -> done=01 and err=1 together after 32 WAIT cycles, result=0x00. Without the macro -> busy stays high indefinitely and err stays 0.
